// File: rtl/bit_stuffer_pkg.sv
// Shared definitions for the USB bit stuffer (transmit) and its receive-side
// unstuffer counterpart: FSM state encoding and the packet-format constants.
package bit_stuffer_pkg;

  // Leading packet bits (the PID) that are exempt from stuffing
  localparam int USB_PID_BITS  = 8;
  // Consecutive 1s that force insertion of a 0
  localparam int USB_STUFF_RUN = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PID   = 2'd1,
    DATA  = 2'd2,
    STUFF = 2'd3
  } stuffer_state_t;

endpackage

// File: rtl/bit_stuffer_if.sv
// Serial bit-stream bundle between the CRC generator, the bit stuffer and the
// NRZI encoder.
//   s_in/in_valid/start_stuffer/end_stuffer : upstream bit and packet framing
//   in_ready                                : stuffer accepts the bit this cycle
//   s_out/out_valid/start_nrzi/end_nrzi     : registered stream to NRZI encoder
// master: the side that feeds bits in and observes the stuffed stream.
// slave : the stuffer itself.
interface bit_stuffer_if;
  logic s_in;
  logic in_valid;
  logic start_stuffer;
  logic end_stuffer;
  logic in_ready;
  logic s_out;
  logic out_valid;
  logic start_nrzi;
  logic end_nrzi;

  modport master (
    output s_in, in_valid, start_stuffer, end_stuffer,
    input  in_ready, s_out, out_valid, start_nrzi, end_nrzi
  );

  modport slave (
    input  s_in, in_valid, start_stuffer, end_stuffer,
    output in_ready, s_out, out_valid, start_nrzi, end_nrzi
  );
endinterface

// File: rtl/bit_stuffer_counter.sv
// Generic up-counter with synchronous clear and count enable.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : increment this cycle
//   clr        : return to zero this cycle (wins over en)
//   count_q    : current count
module counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count_q
);

  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/bit_stuffer.sv
// Transmit-side USB bit stuffer. Passes the PID through untouched, then inserts
// a 0 after every RUN_LEN consecutive 1s, stalling upstream for that cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   abort       : synchronous packet drop, highest priority
//   stuff_busy  : packet in progress (state != IDLE)
//   bus (slave) : input bit stream with framing, in_ready, registered output
//                 stream with start/end qualifiers to the NRZI encoder
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a bit flagged start_stuffer
// PID   | passing PID bits through, counting them in pid_cnt
// DATA  | passing payload/CRC bits, tracking the run of 1s in ones_cnt
// STUFF | emitting the inserted 0; upstream is held off (in_ready=0)
module bit_stuffer
  import bit_stuffer_pkg::*;
#(
  parameter int PID_BITS = USB_PID_BITS,
  parameter int RUN_LEN  = USB_STUFF_RUN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abort,
  output logic stuff_busy,
  bit_stuffer_if.slave bus
);

  localparam int PW = $clog2(PID_BITS + 1);
  localparam int OW = $clog2(RUN_LEN + 1);
  localparam logic [PW-1:0] PID_LAST  = PW'(PID_BITS - 1);
  localparam logic [OW-1:0] ONES_LAST = OW'(RUN_LEN - 1);

  stuffer_state_t cs_q, cs_d;
  logic s_out_q, s_out_d;
  logic out_valid_q, out_valid_d;
  logic start_nrzi_q, start_nrzi_d;
  logic end_nrzi_q, end_nrzi_d;
  logic pending_end_q, pending_end_d;

  logic          pid_en, pid_clr;
  logic          ones_en, ones_clr;
  logic [PW-1:0] pid_cnt_q;
  logic [OW-1:0] ones_cnt_q;

  logic in_ready;
  logic accept;

  // Ready depends on state alone so there is no in_valid -> in_ready path.
  assign in_ready = (cs_q != STUFF);
  assign accept   = bus.in_valid & in_ready & ~abort;

  counter #(.W(PW)) u_pid_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pid_en),
    .clr     (pid_clr),
    .count_q (pid_cnt_q)
  );

  counter #(.W(OW)) u_ones_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ones_en),
    .clr     (ones_clr),
    .count_q (ones_cnt_q)
  );

  always_comb begin
    cs_d          = cs_q;
    s_out_d       = 1'b0;
    out_valid_d   = 1'b0;
    start_nrzi_d  = 1'b0;
    end_nrzi_d    = 1'b0;
    pending_end_d = pending_end_q;
    pid_en        = 1'b0;
    pid_clr       = 1'b0;
    ones_en       = 1'b0;
    ones_clr      = 1'b0;

    if (abort) begin
      cs_d          = IDLE;
      pending_end_d = 1'b0;
      pid_clr       = 1'b1;
      ones_clr      = 1'b1;
    end else begin
      unique case (cs_q)
        IDLE: begin
          if (accept && bus.start_stuffer) begin
            s_out_d      = bus.s_in;
            out_valid_d  = 1'b1;
            start_nrzi_d = 1'b1;
            pid_en       = 1'b1;
            ones_clr     = 1'b1;
            if (bus.end_stuffer) begin
              // Single-bit packet: counter goes straight back to zero.
              end_nrzi_d = 1'b1;
              pid_clr    = 1'b1;
            end else begin
              cs_d = (PID_BITS == 1) ? DATA : PID;
            end
          end
        end

        PID: begin
          if (accept) begin
            s_out_d     = bus.s_in;
            out_valid_d = 1'b1;
            pid_en      = 1'b1;
            if (bus.end_stuffer) begin
              // Handshake packets are PID-only.
              end_nrzi_d = 1'b1;
              cs_d       = IDLE;
              pid_clr    = 1'b1;
            end else if (pid_cnt_q == PID_LAST) begin
              cs_d = DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            s_out_d     = bus.s_in;
            out_valid_d = 1'b1;
            if (bus.s_in)
              ones_en = 1'b1;
            else
              ones_clr = 1'b1;
            if (bus.s_in && (ones_cnt_q == ONES_LAST)) begin
              // The stuff bit follows even the last bit; remember whether
              // it must carry end_nrzi.
              cs_d          = STUFF;
              pending_end_d = bus.end_stuffer;
            end else if (bus.end_stuffer) begin
              end_nrzi_d = 1'b1;
              cs_d       = IDLE;
              pid_clr    = 1'b1;
              ones_clr   = 1'b1;
            end
          end
        end

        STUFF: begin
          s_out_d     = 1'b0;
          out_valid_d = 1'b1;
          end_nrzi_d  = pending_end_q;
          ones_clr    = 1'b1;
          if (pending_end_q) begin
            cs_d          = IDLE;
            pending_end_d = 1'b0;
            pid_clr       = 1'b1;
          end else begin
            cs_d = DATA;
          end
        end

        default: begin
          cs_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q          <= IDLE;
      s_out_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      start_nrzi_q  <= 1'b0;
      end_nrzi_q    <= 1'b0;
      pending_end_q <= 1'b0;
    end else begin
      cs_q          <= cs_d;
      s_out_q       <= s_out_d;
      out_valid_q   <= out_valid_d;
      start_nrzi_q  <= start_nrzi_d;
      end_nrzi_q    <= end_nrzi_d;
      pending_end_q <= pending_end_d;
    end
  end

  assign stuff_busy     = (cs_q != IDLE);
  assign bus.in_ready   = in_ready;
  assign bus.s_out      = s_out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.start_nrzi = start_nrzi_q;
  assign bus.end_nrzi   = end_nrzi_q;

endmodule
